// File: rtl/mmio_shift_led_if.sv
// CPU-side register bus for the shift-register LED driver.
// Reads are combinational; writes are single-cycle strobes.
interface mmio_shift_led_if;
  logic [31:0] rw_addr;
  logic [31:0] w_data;
  logic        w_en;
  logic [31:0] r_data;
  logic        r_hit;

  modport master (output rw_addr, w_data, w_en, input r_data, r_hit);
  modport slave  (input rw_addr, w_data, w_en, output r_data, r_hit);
endinterface

// File: rtl/mmio_shift_led.sv
// Memory-mapped multi-channel driver for 74HC595-style serial chains.
// Each channel has a data register, a one-deep pending buffer and a sticky overrun flag.
module mmio_shift_led #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CLK_DIV     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_03c0,
  parameter logic [31:0] STATUS_ADDR = 32'h0000_03f8
) (
  input  logic              clock,
  input  logic              reset,
  mmio_shift_led_if.slave   bus,
  output logic [NUM_CH-1:0] ser_out,
  output logic [NUM_CH-1:0] sclk_out,
  output logic [NUM_CH-1:0] latch_out
);
  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_t;

  logic                           aligned;
  logic                           status_wr;
  logic [NUM_CH-1:0]              busy;
  logic [NUM_CH-1:0]              pend;
  logic [NUM_CH-1:0]              ovr;
  logic [NUM_CH-1:0][DATA_W-1:0]  shadow;
  logic                           unused_w_data;

  assign aligned       = (bus.rw_addr[1:0] == 2'b00);
  assign status_wr     = bus.w_en && aligned && (bus.rw_addr == STATUS_ADDR);
  assign unused_w_data = ^bus.w_data;

  // Combinational read mux: status word or zero-extended shadow of a channel
  always_comb begin
    bus.r_data = '0;
    bus.r_hit  = 1'b0;
    if (bus.rw_addr == STATUS_ADDR) begin
      bus.r_hit                            = 1'b1;
      bus.r_data[NUM_CH-1:0]               = busy;
      bus.r_data[2*NUM_CH-1:NUM_CH]        = pend;
      bus.r_data[3*NUM_CH-1:2*NUM_CH]      = ovr;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rw_addr == BASE_ADDR + 32'(4 * i)) begin
        bus.r_hit  = 1'b1;
        bus.r_data = 32'(shadow[i]);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [31:0] CH_ADDR = BASE_ADDR + 32'(4 * g);

    state_t            st_q, st_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] pbuf_q, pbuf_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              pend_q, pend_d;
    logic              ovr_q, ovr_d;
    logic              ser_q, sclk_q, latch_q;
    logic              wr, clr, xfer, ovr_set;

    assign wr  = bus.w_en && aligned && (bus.rw_addr == CH_ADDR);
    assign clr = status_wr && bus.w_data[2*NUM_CH+g];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        st_q     <= ST_IDLE;
        div_q    <= '0;
        bit_q    <= '0;
        sh_q     <= '0;
        pbuf_q   <= '0;
        shadow_q <= '0;
        pend_q   <= 1'b0;
        ovr_q    <= 1'b0;
        ser_q    <= 1'b0;
        sclk_q   <= 1'b0;
        latch_q  <= 1'b0;
      end else begin
        st_q     <= st_d;
        div_q    <= div_d;
        bit_q    <= bit_d;
        sh_q     <= sh_d;
        pbuf_q   <= pbuf_d;
        shadow_q <= shadow_d;
        pend_q   <= pend_d;
        ovr_q    <= ovr_d;
        // Pins are registered from next-state so they line up with the state itself
        ser_q    <= (st_d == ST_SHIFT) && sh_d[DATA_W-1];
        sclk_q   <= (st_d == ST_SHIFT) && (div_d >= DIV_W'(CLK_DIV));
        latch_q  <= (st_d == ST_LATCH);
      end
    end

    always_comb begin
      st_d     = st_q;
      div_d    = div_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      pbuf_d   = pbuf_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      xfer     = 1'b0;
      ovr_set  = 1'b0;

      case (st_q)
        ST_IDLE: begin
          if (wr) begin
            st_d  = ST_SHIFT;
            sh_d  = bus.w_data[DATA_W-1:0];
            bit_d = BIT_W'(DATA_W - 1);
            div_d = '0;
          end
        end
        ST_SHIFT: begin
          if (div_q == DIV_W'(2 * CLK_DIV - 1)) begin
            div_d = '0;
            if (bit_q == '0) begin
              st_d = ST_LATCH;
            end else begin
              bit_d = bit_q - BIT_W'(1);
              sh_d  = sh_q << 1;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        ST_LATCH: begin
          if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_d = '0;
            if (pend_q) begin
              st_d   = ST_SHIFT;
              sh_d   = pbuf_q;
              bit_d  = BIT_W'(DATA_W - 1);
              pend_d = 1'b0;
              xfer   = 1'b1;
            end else begin
              st_d = ST_IDLE;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: st_d = ST_IDLE;
      endcase

      // A write racing the pending->shifter transfer refills pending without overrun
      if (wr) begin
        shadow_d = bus.w_data[DATA_W-1:0];
        if (st_q != ST_IDLE) begin
          pbuf_d  = bus.w_data[DATA_W-1:0];
          ovr_set = pend_q && !xfer;
          pend_d  = 1'b1;
        end
      end
      ovr_d = ovr_set | (ovr_q & ~clr);
    end

    assign busy[g]      = (st_q != ST_IDLE);
    assign pend[g]      = pend_q;
    assign ovr[g]       = ovr_q;
    assign shadow[g]    = shadow_q;
    assign ser_out[g]   = ser_q;
    assign sclk_out[g]  = sclk_q;
    assign latch_out[g] = latch_q;
  end
endmodule

// File: tb/tb_mmio_shift_led.sv
// Directed bench for mmio_shift_led: waveforms are captured per cycle into bit vectors
// (bit c = cycle c after the write edge) and compared with hand-computed patterns.
module tb_mmio_shift_led;
  localparam int unsigned NUM_CH = 2;
  localparam logic [31:0] BASE   = 32'h0000_03c0;
  localparam logic [31:0] STAT   = 32'h0000_03f8;

  logic              clock = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ser_out, sclk_out, latch_out;

  mmio_shift_led_if bus ();

  mmio_shift_led #(
    .NUM_CH(NUM_CH), .DATA_W(8), .CLK_DIV(2), .BASE_ADDR(BASE), .STATUS_ADDR(STAT)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .ser_out(ser_out), .sclk_out(sclk_out), .latch_out(latch_out)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_bad = 0;

  logic [127:0] v_ser0, v_sclk0, v_latch0, v_busy0, v_pend0, v_ovr0;
  logic [127:0] v_ser1, v_sclk1, v_latch1, v_busy1;

  int          s_cyc[$];
  logic [31:0] s_addr[$];
  logic [31:0] s_data[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rng(input int lo, input int hi);
    logic [127:0] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Serial pattern of one 8-bit frame, CLK_DIV=2: each bit for 4 cycles over cycles 1..32
  function automatic logic [127:0] ser_model(input logic [7:0] d);
    logic [127:0] v;
    v = '0;
    for (int c = 1; c <= 32; c++) v[c] = d[7 - (c - 1) / 4];
    return v;
  endfunction

  task automatic sched(input int c, input logic [31:0] a, input logic [31:0] d);
    s_cyc.push_back(c);
    s_addr.push_back(a);
    s_data.push_back(d);
  endtask

  // Sample cycle c at the negedge, then drive the write scheduled for edge c
  task automatic run(input int n);
    v_ser0 = '0; v_sclk0 = '0; v_latch0 = '0; v_busy0 = '0; v_pend0 = '0; v_ovr0 = '0;
    v_ser1 = '0; v_sclk1 = '0; v_latch1 = '0; v_busy1 = '0;
    for (int c = 0; c <= n; c++) begin
      @(negedge clock);
      bus.w_en = 1'b0; bus.rw_addr = STAT; bus.w_data = '0;
      #1;
      v_ser0[c]   = ser_out[0];   v_sclk0[c] = sclk_out[0]; v_latch0[c] = latch_out[0];
      v_ser1[c]   = ser_out[1];   v_sclk1[c] = sclk_out[1]; v_latch1[c] = latch_out[1];
      v_busy0[c]  = bus.r_data[0]; v_busy1[c] = bus.r_data[1];
      v_pend0[c]  = bus.r_data[2]; v_ovr0[c]  = bus.r_data[4];
      for (int k = 0; k < s_cyc.size(); k++) begin
        if (s_cyc[k] == c) begin
          bus.w_en = 1'b1; bus.rw_addr = s_addr[k]; bus.w_data = s_data[k];
        end
      end
    end
    bus.w_en = 1'b0; bus.rw_addr = STAT; bus.w_data = '0;
    s_cyc.delete(); s_addr.delete(); s_data.delete();
  endtask

  initial begin
    reset = 1'b1;
    bus.w_en = 1'b0; bus.rw_addr = STAT; bus.w_data = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_status", 128'(bus.r_data), 128'h0);
    chk("rst_pins", 128'({ser_out, sclk_out, latch_out}), 128'h0);
    reset = 1'b0;

    // 1: single 0xA5 frame on ch0
    sched(0, BASE, 32'hA5);
    run(36);
    chk("t1_busy",  v_busy0,  128'h7_FFFF_FFFE);
    chk("t1_ser",   v_ser0,   128'h1_E1E0_1E1E);
    chk("t1_sclk",  v_sclk0,  128'h1_9999_9998);
    chk("t1_latch", v_latch0, 128'h6_0000_0000);
    chk("t1_ch1_quiet", v_busy1 | v_ser1 | v_sclk1 | v_latch1, 128'h0);

    // 2: second write queues into pending and runs back-to-back
    sched(0, BASE, 32'h11);
    sched(5, BASE, 32'h22);
    run(72);
    chk("t2_pend",  v_pend0,  rng(6, 34));
    chk("t2_busy",  v_busy0,  rng(1, 68));
    chk("t2_ser",   v_ser0,   ser_model(8'h11) | (ser_model(8'h22) << 34));
    chk("t2_latch", v_latch0, rng(33, 34) | rng(67, 68));
    chk("t2_ovr",   v_ovr0,   128'h0);

    // 3: third write overwrites pending and sets sticky overrun
    sched(0, BASE, 32'h11);
    sched(5, BASE, 32'h22);
    sched(6, BASE, 32'h33);
    run(72);
    chk("t3_ovr",  v_ovr0,  rng(7, 72));
    chk("t3_pend", v_pend0, rng(6, 34));
    chk("t3_ser",  v_ser0,  ser_model(8'h11) | (ser_model(8'h33) << 34));
    bus.rw_addr = BASE;
    #1;
    chk("t3_shadow", 128'(bus.r_data), 128'h33);
    chk("t3_shadow_hit", 128'(bus.r_hit), 128'h1);
    @(negedge clock);
    bus.w_en = 1'b1; bus.rw_addr = STAT; bus.w_data = 32'h0000_0010;
    @(negedge clock);
    bus.w_en = 1'b0;
    #1;
    chk("t3_w1c", 128'(bus.r_data), 128'h0);

    // 4: both channels running concurrently
    sched(0, BASE,     32'hC3);
    sched(1, BASE + 4, 32'h5A);
    run(38);
    chk("t4_ser0",   v_ser0,   ser_model(8'hC3));
    chk("t4_ser1",   v_ser1,   ser_model(8'h5A) << 1);
    chk("t4_sclk1",  v_sclk1,  128'h3_3333_3330);
    chk("t4_latch1", v_latch1, rng(34, 35));
    chk("t4_busy1",  v_busy1,  rng(2, 35));
    chk("t4_both",   v_busy0 & v_busy1, rng(2, 34));

    // 5: reset in the middle of a frame
    sched(0, BASE, 32'hFF);
    run(9);
    @(negedge clock);
    #1;
    chk("t5_pre_ser", 128'(ser_out[0]), 128'h1);
    reset = 1'b1;
    #1;
    chk("t5_pins", 128'({ser_out, sclk_out, latch_out}), 128'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t5_status", 128'(bus.r_data), 128'h0);
    sched(0, BASE, 32'h81);
    run(36);
    chk("t5_ser",   v_ser0,   ser_model(8'h81));
    chk("t5_latch", v_latch0, 128'h6_0000_0000);
    chk("t5_busy",  v_busy0,  rng(1, 34));

    // 6: unmapped, misaligned and idle status accesses
    @(negedge clock);
    bus.rw_addr = 32'h0000_03fc;
    #1;
    chk("t6_unmap_hit",  128'(bus.r_hit), 128'h0);
    chk("t6_unmap_data", 128'(bus.r_data), 128'h0);
    bus.rw_addr = STAT;
    #1;
    chk("t6_stat_hit",  128'(bus.r_hit), 128'h1);
    chk("t6_stat_data", 128'(bus.r_data), 128'h0);
    sched(0, 32'h0000_03fc, 32'hFF);
    sched(1, 32'h0000_03c1, 32'hFF);
    sched(2, STAT, 32'hFFFF_FFFF);
    run(8);
    chk("t6_no_busy", v_busy0 | v_busy1 | v_pend0 | v_ovr0, 128'h0);
    chk("t6_no_pins", v_ser0 | v_sclk0 | v_latch0 | v_ser1 | v_sclk1 | v_latch1, 128'h0);
    bus.rw_addr = BASE;
    #1;
    chk("t6_shadow_kept", 128'(bus.r_data), 128'h81);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/mmio_shift_led.md
Name: mmio_shift_led

Overview:
- Parametrised memory-mapped LED/output driver that replaces the single-channel LED peripheral.
- Decodes CPU data-bus writes to NUM_CH channel data registers plus one status/control register.
- Each channel serialises DATA_W bits onto an external 74HC595-style chain (ser/sclk/latch) with a programmable bit rate.
- Each channel has a one-deep pending buffer and a sticky overrun flag; reads return combinationally for the top-level read mux.

Parameters:
- NUM_CH, 2, number of independent channels (1..10).
- DATA_W, 8, bits per frame (1..32).
- CLK_DIV, 2, clock cycles per sclk half-period (>=1).
- BASE_ADDR, 32'h0000_03c0, channel i data register at BASE_ADDR + 4*i.
- STATUS_ADDR, 32'h0000_03f8, status/control register address.

Ports:
- clock  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-high.
- rw_addr  input  32  byte address from CPU.
- w_data  input  32  write data; only [DATA_W-1:0] used for channel registers.
- w_en  input  1  write strobe, one cycle per write.
- r_data  output  32  combinational read data.
- r_hit  output  1  combinational; 1 when rw_addr matches any register of this block.
- ser_out  output  NUM_CH  serial data per channel.
- sclk_out  output  NUM_CH  shift clock per channel.
- latch_out  output  NUM_CH  storage-register latch pulse per channel.

Behaviour:
- Reset (async): all channels IDLE; pending, overrun, shadow registers and counters cleared; ser/sclk/latch low. Reset mid-frame aborts immediately with no latch pulse.
- Per-channel FSM: IDLE -> SHIFT -> LATCH -> IDLE, or LATCH -> SHIFT when pending is valid.
- IDLE write to data address at posedge N:
  - Shadow and shift register load w_data[DATA_W-1:0].
  - SHIFT entered at N+1; bit counter = DATA_W-1.
- SHIFT:
  - MSB first; ser_out holds the current bit for 2*CLK_DIV cycles.
  - sclk_out is low for the first CLK_DIV cycles and high for the second.
  - After the high phase of bit 0, go to LATCH.
- LATCH: latch_out high and ser_out low for CLK_DIV cycles, then:
  - pending valid -> pending moves to the shift register, SHIFT starts the next cycle, pending cleared;
  - else -> IDLE.
- Frame length: 2*CLK_DIV*DATA_W + CLK_DIV cycles. Status busy bit is 1 for exactly these cycles.
- Write while SHIFT/LATCH:
  - Pending empty -> store in pending; pending bit set.
  - Pending full -> overwrite pending with the new value; set overrun sticky bit.
- Write in the same cycle that pending transfers to the shifter: the new value goes to pending, with no overrun.
- Shadow register always holds the most recently written value (accepted or overwritten).
- Status read, STATUS_ADDR:
  - [NUM_CH-1:0] busy.
  - [2*NUM_CH-1:NUM_CH] pending valid.
  - [3*NUM_CH-1:2*NUM_CH] overrun.
  - All other bits 0.
- Status write: a 1 in an overrun bit position clears that bit (W1C); other bits are ignored. If an overrun set and a clear land in the same cycle, set wins.
- Data address read: r_data = zero-extended shadow.
- Unmapped address: r_hit=0, r_data=0, writes ignored.
- Addresses compare on the full 32 bits; w_en on a non-word-aligned address is ignored.
- Channels are fully independent; writes to different channels never interact.

Test Plan:
1. DATA_W=8, CLK_DIV=2, write 0xA5 to ch0 at cycle 0:
   - busy=1 in cycles 1..34.
   - ser sequence 1,0,1,0,0,1,0,1, four cycles each, over cycles 1..32.
   - sclk high in cycles 3-4, 7-8, ... 31-32.
   - latch high in cycles 33-34; IDLE at cycle 35.
2. Write 0x11 then, at cycle 5, 0x22 to ch0:
   - status reads pending=1 in cycles 6..34.
   - second frame starts at cycle 35 and shifts 0x22; pending=0 from cycle 35; overrun stays 0.
3. Write 0x11, 0x22, 0x33 to ch0 at cycles 0, 5, 6:
   - overrun bit set from cycle 7.
   - second frame shifts 0x33; data-address read returns 0x33.
   - W1C of bit 2*NUM_CH clears overrun.
4. Simultaneous ch0 and ch1 frames with different data:
   - independent correct waveforms; status busy=2'b11 while both are active.
5. Assert reset at cycle 10 of a frame:
   - all outputs low the same cycle; status=0 after release.
   - a new write then produces a full frame with no stale bits.
6. Reads at unmapped address 0x3fc and at STATUS_ADDR with no activity:
   - unmapped address gives r_hit=0, r_data=0.
   - STATUS_ADDR gives r_hit=1, r_data=0.
   - w_en to 0x3fc leaves all channels IDLE.
